// File: rtl/liushuideng_multi.sv
// liushuideng_multi: N-LED chaser with rotate-up, rotate-down, ping-pong and
// bar-fill patterns, advanced once per prescaler period.
// Optional macro LIUSHUIDENG_SPEED_SEL_EN adds a 2-bit speed input that
// stretches the step period to DIV << speed clocks.
module liushuideng_multi #(
  parameter int N          = 8,
  parameter int DIV        = 12,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
`ifdef LIUSHUIDENG_SPEED_SEL_EN
  input  logic [1:0]           speed,
`endif
  output logic [N-1:0]         out,
  output logic                 step,
  output logic [$clog2(N)-1:0] pos
);

  localparam int PW = $clog2(N);
`ifdef LIUSHUIDENG_SPEED_SEL_EN
  localparam int CW = $clog2(8 * DIV);
`else
  localparam int CW = $clog2(DIV);
`endif

  localparam logic [PW-1:0] POS_LAST = PW'(N - 1);
  localparam logic [N-1:0]  OUT_RST  = (ACTIVE_LOW != 0) ? ~N'(1) : N'(1);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_BAR  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  dir_e          dir_q, dir_d;
  mode_e         mode_q, mode_d;
  logic [N-1:0]  out_q, out_d;
  logic          step_q, step_d;
  logic [N-1:0]  lit;
  logic          tick;

`ifdef LIUSHUIDENG_SPEED_SEL_EN
  logic [1:0]    speed_q, speed_d;
  logic [CW:0]   term_wide;

  // Terminal count uses the speed latched at the previous tick, so a new
  // speed only affects the period that starts after the current one ends.
  always_comb begin
    term_wide = ((CW + 1)'(DIV) << speed_q) - (CW + 1)'(1);
    tick      = en && ({1'b0, cnt_q} == term_wide);
  end
`else
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  // Prescaler terminal-count detect; suppressed while disabled.
  always_comb begin
    tick = en && (cnt_q == TERM);
  end
`endif

  // State register: synchronous reset restarts the pattern at LED0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= mode_e'(mode);
      out_q   <= OUT_RST;
      step_q  <= 1'b0;
`ifdef LIUSHUIDENG_SPEED_SEL_EN
      speed_q <= speed;
`endif
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      step_q  <= step_d;
`ifdef LIUSHUIDENG_SPEED_SEL_EN
      speed_q <= speed_d;
`endif
    end
  end

  // Next-state: prescaler count, and on tick either restart or advance.
  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
`ifdef LIUSHUIDENG_SPEED_SEL_EN
    speed_d = speed_q;
`endif
    if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
`ifdef LIUSHUIDENG_SPEED_SEL_EN
      speed_d = speed;
`endif
      if (mode_e'(mode) != mode_q) begin
        mode_d = mode_e'(mode);
        pos_d  = '0;
        dir_d  = DIR_UP;
      end else begin
        case (mode_q)
          MODE_UP, MODE_BAR: begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
          end
          MODE_DOWN: begin
            pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
          end
          MODE_PING: begin
            // Direction flips as an end is reached, so ends are not repeated.
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                pos_d = pos_q - PW'(1);
                dir_d = DIR_DOWN;
              end else begin
                pos_d = pos_q + PW'(1);
                if (pos_q == POS_LAST - PW'(1)) dir_d = DIR_DOWN;
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = PW'(1);
                dir_d = DIR_UP;
              end else begin
                pos_d = pos_q - PW'(1);
                if (pos_q == PW'(1)) dir_d = DIR_UP;
              end
            end
          end
          default: begin
            pos_d = '0;
          end
        endcase
      end
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output decode from next-state pos/mode, registered into out_q.
  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mode_d == MODE_BAR) lit[i] = (PW'(i) <= pos_d);
      else                    lit[i] = (PW'(i) == pos_d);
    end
    out_d = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  assign out  = out_q;
  assign step = step_q;
  assign pos  = pos_q;

endmodule

// File: doc/liushuideng_multi.md
Name: liushuideng_multi

Overview:
- Parametrised multi-mode LED chaser: N-bit light bar driven by an internal prescaler; one position step per prescaler period.
- Modes: rotate up, rotate down, ping-pong, bar fill. Adds enable, synchronous reset, mode switching and a step strobe.
- Sits directly on the board LED pins, clocked from the board oscillator.

Parameters:
- N, 8, number of LEDs (N >= 2).
- DIV, 12, clocks per step (DIV >= 2). The prescaler counts 0..DIV-1.
- ACTIVE_LOW, 1, when 1 a lit LED drives 0 on out; when 0 a lit LED drives 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  1 = run; 0 = freeze prescaler and pattern (out holds).
- mode  in  2  00 rotate up, 01 rotate down, 10 ping-pong, 11 bar fill.
- out  out  N  LED drive, registered; polarity per ACTIVE_LOW.
- step  out  1  one-cycle pulse on the cycle the pattern advances.
- pos  out  clog2(N)  current position or level, registered.

Behaviour:
- Reset: rst=1 at a rising edge sets the following, overriding all other inputs:
  - cnt=0, pos=0, dir=up, mode_q=mode, step=0.
  - out = LED0 lit only. For ACTIVE_LOW=1, N=8 this is 8'b11111110.
- Prescaler:
  - If en=1 and cnt==DIV-1: cnt<=0 and an internal tick is asserted that cycle. Otherwise, if en=1, cnt<=cnt+1.
  - If en=0, cnt holds and no tick occurs.
- Advance: on the edge where tick=1, pos, dir, mode_q and out all update together. step is registered high for exactly the next cycle, so step=1 coincides with the first cycle of the new out.
- Mode change: mode is sampled only at tick.
  - If mode differs from mode_q at tick: mode_q<=mode, pos<=0, dir<=up, and out is the new mode's pattern at position 0.
  - A mode change between ticks has no effect until the next tick.
- Mode 00 rotate up: pos 0,1,...,N-1,0. Lit = bit pos only.
- Mode 01 rotate down: pos 0,N-1,N-2,...,1,0. Lit = bit pos only.
- Mode 10 ping-pong:
  - dir=up: pos+1. On reaching N-1, dir<=down.
  - dir=down: pos-1. On reaching 0, dir<=up.
  - End positions are not repeated: the sequence for N=4 is 0,1,2,3,2,1,0,1.
  - Lit = bit pos only.
- Mode 11 bar fill: level pos 0..N-1, wrapping from N-1 to 0. Lit = bits 0..pos inclusive. At N-1 all LEDs are lit.
- out decode:
  - Computed from the next-state pos and mode, then registered; no combinational path from inputs to out.
  - For ACTIVE_LOW=1, out = ~lit_vector.
- Simultaneous events:
  - rst beats en and tick.
  - A tick with a mode change applies the restart rule, not an advance.
  - en falling on a would-be tick cycle suppresses that tick.
- Reset mid-run: the next cycle matches the reset state, whatever the prior cnt, pos or mode. The first advance follows DIV enabled cycles later.
- Width: cnt is wide enough for DIV-1. pos arithmetic wraps modulo N explicitly, with no reliance on binary overflow for non-power-of-2 N.

Optional Feature:
- Macro LIUSHUIDENG_SPEED_SEL_EN.
- Defined:
  - Adds input speed (2 bits).
  - Prescaler terminal count becomes (DIV<<speed)-1, i.e. step period DIV, 2*DIV, 4*DIV or 8*DIV.
  - speed is sampled at each tick. A new value takes effect from the following prescaler period, and the current period completes at the old rate.
  - cnt is widened to hold 8*DIV-1.
- Undefined: the speed port does not exist; terminal count is DIV-1.

Test Plan:
- Reset value: N=8, DIV=4, rst for 2 cycles -> out=8'hFE, pos=0, step=0. After release with en=1 -> first step pulse 4 cycles later, then out=8'hFD, pos=1.
- Rotate up/down wrap: mode=00, 8 ticks -> out FE,FD,FB,F7,EF,DF,BF,7F,FE. mode=01 from reset -> FE,7F,BF,...,FD,FE.
- Ping-pong: N=4, DIV=2, mode=10 -> pos 0,1,2,3,2,1,0,1; no repeated 3 or 0; step every 2 cycles.
- Bar fill and mid-run mode change: mode=11, N=8 -> out FE,FC,F8,...,00,FE. Switch mode to 00 when pos=5 -> next tick gives out=FE, pos=0.
- Enable and reset priority: en=0 for 10 cycles mid-period -> out, pos and cnt frozen, no step; resumes the remaining count. rst asserted on a tick cycle with en=1 -> reset state, no step.
- With LIUSHUIDENG_SPEED_SEL_EN, DIV=4: speed=2 -> step period 16 cycles. Change to 0 mid-period -> current period stays 16, next period is 4.
